// File: rtl/ram_readback_checker.sv
`default_nettype none
// ============================================================================
// Module   : ram_readback_checker
// Brief    : Sweeps the RAM read port once, checks each word against the
//            addr+OFFSET fill pattern, counts mismatches, keeps the first one.
// Revision : 1.0 - initial release
// ============================================================================
module ram_readback_checker #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1,
    parameter int OFFSET = 0,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int                    c_STATE_W    = 3;
    localparam logic [c_STATE_W-1:0]  c_S_IDLE     = 3'd0;
    localparam logic [c_STATE_W-1:0]  c_S_WAIT_WR  = 3'd1;
    localparam logic [c_STATE_W-1:0]  c_S_READ     = 3'd2;
    localparam logic [c_STATE_W-1:0]  c_S_DRAIN    = 3'd3;
    localparam logic [c_STATE_W-1:0]  c_S_DONE     = 3'd4;

    localparam int                    c_DRAIN_W    = $clog2(RD_LAT + 1);
    localparam logic [c_DRAIN_W-1:0]  c_DRAIN_LAST = c_DRAIN_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0]     c_LAST_ADDR  = '1;
    localparam logic [ERR_W-1:0]      c_ERR_MAX    = '1;
    localparam logic [DATA_W-1:0]     c_OFFSET     = DATA_W'(OFFSET);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic [RD_LAT-1:0]    r_pipe_valid;
    logic [ADDR_W-1:0]    r_pipe_addr [RD_LAT];
    logic                 r_err_seen;
    logic [ERR_W-1:0]     r_err_count;
    logic [ADDR_W-1:0]    r_first_addr;
    logic [DATA_W-1:0]    r_first_data;

    logic                 w_launch;
    logic [DATA_W-1:0]    w_expected;
    logic                 w_mismatch;

    assign w_launch   = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    // The oldest pipeline entry lines up with the word now on rd_data.
    assign w_expected = DATA_W'(r_pipe_addr[RD_LAT-1]) + c_OFFSET;
    assign w_mismatch = r_pipe_valid[RD_LAT-1] && (rd_data != w_expected);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:    if (start)                        w_next_state = c_S_WAIT_WR;
            c_S_WAIT_WR: if (wr_done)                      w_next_state = c_S_READ;
            c_S_READ:    if (r_addr == c_LAST_ADDR)        w_next_state = c_S_DRAIN;
            c_S_DRAIN:   if (r_drain_cnt == c_DRAIN_LAST)  w_next_state = c_S_DONE;
            c_S_DONE:    if (start)                        w_next_state = c_S_WAIT_WR;
            default:                                       w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        rd_addr        = (r_state == c_S_READ) ? r_addr : '0;
        busy           = (r_state == c_S_WAIT_WR) || (r_state == c_S_READ) ||
                         (r_state == c_S_DRAIN);
        done           = (r_state == c_S_DONE);
        pass           = done && (r_err_count == '0);
        err_count      = r_err_count;
        first_err_addr = r_first_addr;
        first_err_data = r_first_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_drain_cnt  <= '0;
            r_pipe_valid <= '0;
            r_err_seen   <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
        end else begin
            // The counter wraps to 0 on the last address, which is also the exit from READ.
            r_addr          <= (r_state == c_S_READ) ? r_addr + 1'b1 : '0;
            r_drain_cnt     <= (r_state == c_S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
            r_pipe_valid[0] <= (r_state == c_S_READ);
            r_pipe_addr[0]  <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_addr[i]  <= r_pipe_addr[i-1];
            end

            if (w_launch) begin
                r_pipe_valid <= '0;
                r_err_seen   <= 1'b0;
                r_err_count  <= '0;
                r_first_addr <= '0;
                r_first_data <= '0;
            end else if (w_mismatch) begin
                if (r_err_count != c_ERR_MAX) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (!r_err_seen) begin
                    r_err_seen   <= 1'b1;
                    r_first_addr <= r_pipe_addr[RD_LAT-1];
                    r_first_data <= rd_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_readback_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_readback_checker
// Brief    : Directed bench for ram_readback_checker with RAM models and a
//            result scoreboard across three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_readback_checker;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int NW = 1 << AW;

    typedef struct {
        int          cyc;
        logic [31:0] err;
        logic [31:0] fea;
        logic [31:0] fed;
        logic [31:0] pass;
    } result_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] busy;
        logic [31:0] done;
        logic [31:0] pass;
        logic [31:0] err;
        logic [31:0] fea;
        logic [31:0] fed;
    } obs_t;

    result_t exp_q[$];
    int      addr_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    // DUT a: defaults
    logic          a_start, a_wr_done, a_busy, a_done, a_pass;
    logic [AW-1:0] a_rd_addr, a_fea;
    logic [DW-1:0] a_rd_data, a_fed, a_q;
    logic [15:0]   a_err;
    logic [DW-1:0] a_mem [NW];
    // DUT b: OFFSET=5
    logic          b_start, b_wr_done, b_busy, b_done, b_pass;
    logic [AW-1:0] b_rd_addr, b_fea;
    logic [DW-1:0] b_rd_data, b_fed, b_q;
    logic [15:0]   b_err;
    logic [DW-1:0] b_mem [NW];
    // DUT c: RD_LAT=2, ERR_W=4
    logic          c_start, c_wr_done, c_busy, c_done, c_pass;
    logic [AW-1:0] c_rd_addr, c_fea;
    logic [DW-1:0] c_rd_data, c_fed, c_q1, c_q2;
    logic [3:0]    c_err;
    logic [DW-1:0] c_mem [NW];

    always_ff @(posedge clk) begin
        a_q  <= a_mem[a_rd_addr];
        b_q  <= b_mem[b_rd_addr];
        c_q1 <= c_mem[c_rd_addr];
        c_q2 <= c_q1;
    end
    assign a_rd_data = a_q;
    assign b_rd_data = b_q;
    assign c_rd_data = c_q2;

    ram_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .OFFSET(0), .ERR_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .wr_done(a_wr_done), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .first_err_addr(a_fea), .first_err_data(a_fed));

    ram_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .OFFSET(5), .ERR_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .wr_done(b_wr_done), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .first_err_addr(b_fea), .first_err_data(b_fed));

    ram_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .OFFSET(0), .ERR_W(4)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .wr_done(c_wr_done), .rd_addr(c_rd_addr),
        .rd_data(c_rd_data), .busy(c_busy), .done(c_done), .pass(c_pass), .err_count(c_err),
        .first_err_addr(c_fea), .first_err_data(c_fed));

    function automatic obs_t snap(input int sel);
        obs_t o;
        case (sel)
            0: begin
                o.addr = 32'(a_rd_addr); o.busy = 32'(a_busy); o.done = 32'(a_done);
                o.pass = 32'(a_pass); o.err = 32'(a_err); o.fea = 32'(a_fea); o.fed = 32'(a_fed);
            end
            1: begin
                o.addr = 32'(b_rd_addr); o.busy = 32'(b_busy); o.done = 32'(b_done);
                o.pass = 32'(b_pass); o.err = 32'(b_err); o.fea = 32'(b_fea); o.fed = 32'(b_fed);
            end
            default: begin
                o.addr = 32'(c_rd_addr); o.busy = 32'(c_busy); o.done = 32'(c_done);
                o.pass = 32'(c_pass); o.err = 32'(c_err); o.fea = 32'(c_fea); o.fed = 32'(c_fed);
            end
        endcase
        return o;
    endfunction

    task automatic drive(input int sel, input logic s, input logic w);
        case (sel)
            0:       begin a_start = s; a_wr_done = w; end
            1:       begin b_start = s; b_wr_done = w; end
            default: begin c_start = s; c_wr_done = w; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int sel, input string tag);
        obs_t o;
        o = snap(sel);
        chk({tag, "_rd_addr"}, o.addr, 0);
        chk({tag, "_busy"},    o.busy, 0);
        chk({tag, "_done"},    o.done, 0);
        chk({tag, "_pass"},    o.pass, 0);
        chk({tag, "_err"},     o.err,  0);
        chk({tag, "_fea"},     o.fea,  0);
        chk({tag, "_fed"},     o.fed,  0);
    endtask

    // Starts a sweep on DUT sel; cycle index 0 is the cycle after the start edge.
    task automatic run(input int sel, input int wr_delay, input int restart_at, input bit check_addr);
        obs_t    o;
        result_t e;
        int      cyc;
        int      glitch;
        bit      found;
        int      rd_first;
        int      ea;
        cyc      = 0;
        glitch   = 0;
        found    = 1'b0;
        rd_first = wr_delay + 1;
        @(negedge clk);
        drive(sel, 1'b1, wr_delay == 0);
        @(posedge clk);
        #1 drive(sel, 1'b0, wr_delay == 0);
        while (!found && cyc < 4000) begin
            @(negedge clk);
            o = snap(sel);
            if (o.done === 32'd1) begin
                found = 1'b1;
            end else begin
                if (o.pass !== 32'd0) glitch++;
                if (check_addr && cyc >= rd_first && cyc < rd_first + NW) begin
                    ea = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
                    chk("rd_addr_seq", o.addr, ea);
                end
                if (wr_delay > 0 && cyc == wr_delay / 2) begin
                    chk("wait_busy", o.busy, 1);
                    chk("wait_rd_addr", o.addr, 0);
                end
                if (wr_delay > 0 && cyc == wr_delay) drive(sel, 1'b0, 1'b1);
                if (restart_at > 0 && cyc == restart_at) drive(sel, 1'b1, 1'b1);
                if (restart_at > 0 && cyc == restart_at + 1) drive(sel, 1'b0, 1'b1);
                cyc++;
            end
        end
        e = exp_q.pop_front();
        chk("done_seen",     32'(found), 1);
        chk("done_cycle",    cyc, e.cyc);
        chk("err_count",     o.err, e.err);
        chk("first_err_addr", o.fea, e.fea);
        chk("first_err_data", o.fed, e.fed);
        chk("pass",          o.pass, e.pass);
        chk("pass_early",    glitch, 0);
        chk("done_rd_addr",  o.addr, 0);
        chk("done_busy",     o.busy, 0);
    endtask

    initial begin
        obs_t o;
        int   cyc;
        a_start = 1'b0; a_wr_done = 1'b0;
        b_start = 1'b0; b_wr_done = 1'b0;
        c_start = 1'b0; c_wr_done = 1'b0;
        for (int k = 0; k < NW; k++) begin
            a_mem[k] = DW'(k);
            b_mem[k] = DW'(k + 5);
            c_mem[k] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero(0, "reset_a");
        chk_zero(2, "reset_c");
        rst = 1'b0;

        // Clean fill, full address order check
        for (int k = 0; k < NW; k++) addr_q.push_back(k);
        exp_q.push_back('{cyc: 514, err: 0, fea: 0, fed: 0, pass: 1});
        run(0, 0, 0, 1'b1);

        // Single fault, restarted from DONE
        a_mem[37] = 16'h1234;
        exp_q.push_back('{cyc: 514, err: 1, fea: 37, fed: 32'h1234, pass: 0});
        run(0, 0, 0, 1'b0);
        a_mem[37] = 16'd37;

        // OFFSET=5: clean (word 511 must be 516), then three faults
        exp_q.push_back('{cyc: 514, err: 0, fea: 0, fed: 0, pass: 1});
        run(1, 0, 0, 1'b0);
        b_mem[3]   = 16'hFFFF;
        b_mem[200] = 16'h0000;
        b_mem[511] = 16'd515;
        exp_q.push_back('{cyc: 514, err: 3, fea: 3, fed: 32'hFFFF, pass: 0});
        run(1, 0, 0, 1'b0);

        // RD_LAT=2, 4-bit saturating counter, all-zero RAM
        exp_q.push_back('{cyc: 515, err: 15, fea: 1, fed: 0, pass: 0});
        run(2, 0, 0, 1'b0);

        // wr_done late by 100 cycles, stray start mid-READ
        exp_q.push_back('{cyc: 614, err: 0, fea: 0, fed: 0, pass: 1});
        run(0, 100, 300, 1'b0);
        repeat (20) @(negedge clk);
        o = snap(0);
        chk("hold_done", o.done, 1);
        chk("hold_busy", o.busy, 0);
        chk("hold_err",  o.err,  0);

        // Reset mid-sweep with an error already counted
        a_mem[10] = 16'hBEEF;
        @(negedge clk);
        drive(0, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b1);
        cyc = 0;
        @(negedge clk);
        while (a_rd_addr !== AW'(250) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reach_250", 32'(cyc < 1000), 1);
        chk("pre_rst_err", 32'(a_err), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero(0, "mid_rst");
        @(negedge clk);
        rst = 1'b0;
        a_mem[10] = 16'd10;
        exp_q.push_back('{cyc: 514, err: 0, fea: 0, fed: 0, pass: 1});
        run(0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
